// File: rtl/sh_bus_slave_pkg.sv
// Shared types for the SH7604 CS0 bus responder: FSM states and the latched bus-cycle record.
package sh_bus_slave_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   typedef struct packed {
      logic [26:0] addr;
      logic        rd;
      logic [3:0]  be;
      logic [31:0] data;
   } bus_cycle_t;

   localparam logic [3:0] BE_ALL = 4'hF;

   function automatic logic [26:0] word_align(input logic [26:0] a);
      return {a[26:2], 2'b00};
   endfunction

endpackage

// File: rtl/sh_bus_slave.sv
// SH7604 CS0 external-bus responder: decodes a CPU bus cycle, stretches it with WAIT_N
// and runs one request on a simple backing-memory port.
module sh_bus_slave
   import sh_bus_slave_pkg::*;
#(
   parameter logic [12:0] BASE    = 13'h0000,
   parameter int          ADDR_W  = 14,
   parameter int          WAIT_RD = 2,
   parameter int          WAIT_WR = 1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CE_R,
   input  logic [26:0]       A,
   input  logic [31:0]       DI,
   output logic [31:0]       DO,
   input  logic              CS_N,
   input  logic              BS_N,
   input  logic              RD_WR_N,
   input  logic [3:0]        WE_N,
   output logic              WAIT_N,
   output logic [ADDR_W-1:0] MEM_A,
   output logic [31:0]       MEM_D,
   output logic [3:0]        MEM_BE,
   output logic              MEM_RD,
   output logic              MEM_WR,
   input  logic [31:0]       MEM_Q,
   input  logic              MEM_RDY,
   output logic              ERR
);

   localparam logic [2:0] CNT_RD = 3'(WAIT_RD);
   localparam logic [2:0] CNT_WR = 3'(WAIT_WR);

   state_t     state_r, state_n;
   bus_cycle_t cyc_r, cyc_n;
   logic [2:0] cnt_r, cnt_n;
   logic       done_r, done_n;
   logic       mem_rd_r, mem_rd_n;
   logic       mem_wr_r, mem_wr_n;
   logic       wait_n_r, wait_n_n;
   logic [31:0] do_r, do_n;
   logic       err_r, err_n;
   logic       hit_s;
   logic       rdy_hit_s;
   logic       dummy_s;

   assign hit_s     = !CS_N && !BS_N && (A[26:14] == BASE);
   assign rdy_hit_s = MEM_RDY && (mem_rd_r || mem_wr_r);
   assign dummy_s   = !RD_WR_N && (WE_N == BE_ALL);

   // State and output registers; reset aborts any cycle in flight.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r  <= S_IDLE;
         cyc_r    <= '0;
         cnt_r    <= 3'd0;
         done_r   <= 1'b0;
         mem_rd_r <= 1'b0;
         mem_wr_r <= 1'b0;
         wait_n_r <= 1'b1;
         do_r     <= 32'h0000_0000;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_n;
         cyc_r    <= cyc_n;
         cnt_r    <= cnt_n;
         done_r   <= done_n;
         mem_rd_r <= mem_rd_n;
         mem_wr_r <= mem_wr_n;
         wait_n_r <= wait_n_n;
         do_r     <= do_n;
         err_r    <= err_n;
      end
   end

   // Next-state and next-output logic, advancing only on bus-phase ticks.
   always_comb begin
      state_n  = state_r;
      cyc_n    = cyc_r;
      cnt_n    = cnt_r;
      done_n   = done_r;
      mem_rd_n = mem_rd_r;
      mem_wr_n = mem_wr_r;
      wait_n_n = wait_n_r;
      do_n     = do_r;
      err_n    = err_r;
      if (CE_R) begin
         case (state_r)
            S_IDLE: begin
               if (hit_s) begin
                  cyc_n.addr = word_align(A);
                  cyc_n.rd   = RD_WR_N;
                  cyc_n.be   = RD_WR_N ? BE_ALL : ~WE_N;
                  if (!RD_WR_N) begin
                     cyc_n.data = DI;
                  end else begin
                     cyc_n.data = cyc_r.data;
                  end
                  cnt_n    = RD_WR_N ? CNT_RD : CNT_WR;
                  done_n   = dummy_s;
                  mem_rd_n = RD_WR_N;
                  mem_wr_n = !RD_WR_N && !dummy_s;
                  wait_n_n = 1'b0;
                  state_n  = S_WAIT;
               end else begin
                  state_n = S_IDLE;
               end
            end
            S_WAIT: begin
               if (cnt_r != 3'd0) begin
                  cnt_n = cnt_r - 3'd1;
               end else begin
                  cnt_n = cnt_r;
               end
               if (rdy_hit_s) begin
                  mem_rd_n = 1'b0;
                  mem_wr_n = 1'b0;
                  done_n   = 1'b1;
                  if (cyc_r.rd) begin
                     do_n = MEM_Q;
                  end else begin
                     do_n = do_r;
                  end
               end else begin
                  done_n = done_r;
               end
               // A same-tick acknowledge counts toward completion.
               if ((cnt_r == 3'd0) && (done_r || rdy_hit_s)) begin
                  wait_n_n = 1'b1;
                  state_n  = S_ACK;
               end else begin
                  state_n = S_WAIT;
               end
               if (!BS_N) begin
                  err_n = 1'b1;
               end else begin
                  err_n = err_r;
               end
            end
            S_ACK: begin
               state_n = S_IDLE;
               if (!BS_N) begin
                  err_n = 1'b1;
               end else begin
                  err_n = err_r;
               end
            end
            default: begin
               state_n  = S_IDLE;
               mem_rd_n = 1'b0;
               mem_wr_n = 1'b0;
               wait_n_n = 1'b1;
            end
         endcase
      end else begin
         state_n = state_r;
      end
   end

   assign DO     = do_r;
   assign WAIT_N = wait_n_r;
   assign MEM_A  = cyc_r.addr[ADDR_W-1:0];
   assign MEM_D  = cyc_r.data;
   assign MEM_BE = cyc_r.be;
   assign MEM_RD = mem_rd_r;
   assign MEM_WR = mem_wr_r;
   assign ERR    = err_r;

endmodule
